// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap-around.
module uart_rr_pick #(
  parameter int unsigned num_req_p = 2,
  parameter int unsigned idx_w     = 1
) (
  input  logic [num_req_p-1:0] req,
  input  logic [idx_w-1:0]     ptr,
  output logic [num_req_p-1:0] grant,
  output logic [idx_w-1:0]     idx
);

  logic             found;
  logic [idx_w-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      k = idx_w'((32'(ptr) + i) % num_req_p);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit path among requesters,
// with an idle-owner timeout that revokes a stalled lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned num_req_p        = 2,
  parameter int unsigned data_bits_p      = 8,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*data_bits_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]               req_last_i,
  output logic [num_req_p-1:0]               req_ready_and_o,
  output logic                               tx_v_o,
  output logic [data_bits_p-1:0]             tx_o,
  input  logic                               tx_ready_and_i,
  output logic [num_req_p-1:0]               grant_o,
  output logic                               busy_o,
  output logic                               timeout_o,
  output logic [$clog2(num_req_p)-1:0]       timeout_id_o
);

  localparam int unsigned idx_w      = $clog2(num_req_p);
  localparam int unsigned cnt_w      = (timeout_cycles_p == 0) ? 1 : $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles_p - 1);
  localparam bit timeout_en          = (timeout_cycles_p != 0);

  arb_state_e       state_q, state_d;
  logic [idx_w-1:0] owner_q, owner_d;
  logic [idx_w-1:0] ptr_q, ptr_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [idx_w-1:0] timeout_id_q, timeout_id_d;

  logic [num_req_p-1:0]   pick_oh;
  logic [idx_w-1:0]       pick_idx;
  logic [num_req_p-1:0]   owner_oh;
  logic [num_req_p-1:0]   sel_oh;
  logic [idx_w-1:0]       sel;
  logic [data_bits_p-1:0] data_arr [num_req_p];
  logic                   xfer;

  uart_rr_pick #(
    .num_req_p (num_req_p),
    .idx_w     (idx_w)
  ) u_pick (
    .req   (req_v_i),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  always_comb begin
    for (int unsigned k = 0; k < num_req_p; k++) begin
      data_arr[k] = req_data_i[k*data_bits_p +: data_bits_p];
    end
  end

  // Datapath: pick_oh is already zero when nobody is valid, which gives the idle grant.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    sel               = (state_q == LOCKED) ? owner_q : pick_idx;
    sel_oh            = (state_q == LOCKED) ? owner_oh : pick_oh;
    tx_o              = data_arr[sel];
    tx_v_o            = !reset_i && req_v_i[sel];
    grant_o           = reset_i ? '0 : sel_oh;
    req_ready_and_o   = reset_i ? '0 : (sel_oh & {num_req_p{tx_ready_and_i}});
    xfer              = tx_v_o && tx_ready_and_i;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          if (req_last_i[sel]) begin
            ptr_d = idx_w'(wrap_inc(32'(sel), num_req_p));
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (req_v_i[owner_q]) begin
          cnt_d = '0;
          if (xfer && req_last_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = idx_w'(wrap_inc(32'(owner_q), num_req_p));
          end
        end else if (timeout_en) begin
          // Fire on the cycle the count would reach the limit, so it never wraps.
          if (cnt_q == cnt_last) begin
            state_d      = IDLE;
            ptr_d        = idx_w'(wrap_inc(32'(owner_q), num_req_p));
            timeout_d    = 1'b1;
            timeout_id_d = owner_q;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign busy_o       = (state_q == LOCKED);
  assign timeout_o    = timeout_en ? timeout_q : 1'b0;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte scoreboard on tx_o plus control-signal checks.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8;
  localparam int unsigned T = 4;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_and_o;
  logic           tx_v_o;
  logic [W-1:0]   tx_o;
  logic           tx_ready_and_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;
  logic [0:0]     timeout_id_o;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      src0[$];
  beat_t      src1[$];
  logic [7:0] exp_q[$];
  logic       en0, en1;
  int         n_checks = 0;
  int         n_fail   = 0;

  uart_tx_arbiter #(
    .num_req_p        (N),
    .data_bits_p      (W),
    .timeout_cycles_p (T)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_v_i         (req_v_i),
    .req_data_i      (req_data_i),
    .req_last_i      (req_last_i),
    .req_ready_and_o (req_ready_and_o),
    .tx_v_o          (tx_v_o),
    .tx_o            (tx_o),
    .tx_ready_and_i  (tx_ready_and_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o),
    .timeout_id_o    (timeout_id_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_v_i    = '0;
    req_data_i = '0;
    req_last_i = '0;
    if (src0.size() > 0) begin
      req_v_i[0]        = en0;
      req_data_i[7:0]   = src0[0].data;
      req_last_i[0]     = src0[0].last;
    end
    if (src1.size() > 0) begin
      req_v_i[1]        = en1;
      req_data_i[15:8]  = src1[0].data;
      req_last_i[1]     = src1[0].last;
    end
    #1;
  endtask

  // Observe the handshake mid-cycle, then advance past the next rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk_i);
    if (tx_v_o && tx_ready_and_i) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'(tx_o), 32'h100);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_o), 32'(e));
      end
    end
    if (req_v_i[0] && req_ready_and_o[0]) void'(src0.pop_front());
    if (req_v_i[1] && req_ready_and_o[1]) void'(src1.pop_front());
    @(posedge clk_i);
    #1;
    drive();
  endtask

  initial begin
    reset_i        = 1'b1;
    tx_ready_and_i = 1'b1;
    en0            = 1'b0;
    en1            = 1'b0;
    drive();
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_timeout_id", 32'(timeout_id_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_tx_v", 32'(tx_v_o), 32'd0);
    reset_i = 1'b0;
    #1;

    // Three-byte packet from req0.
    src0.push_back('{8'h41, 1'b0});
    src0.push_back('{8'h42, 1'b0});
    src0.push_back('{8'h43, 1'b1});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    en0 = 1'b1;
    drive();
    chk("s1_busy_c1", 32'(busy_o), 32'd0);
    chk("s1_grant", 32'(grant_o), 32'b01);
    chk("s1_first_byte", 32'(tx_o), 32'h41);
    tick();
    chk("s1_busy_c2", 32'(busy_o), 32'd1);
    tick();
    chk("s1_busy_c3", 32'(busy_o), 32'd1);
    tick();
    chk("s1_busy_after", 32'(busy_o), 32'd0);
    chk("s1_grant_after", 32'(grant_o), 32'd0);
    chk("s1_timeout", 32'(timeout_o), 32'd0);
    chk("s1_drained", 32'(exp_q.size()), 32'd0);

    // Both valid across reset release: req0 wins, no interleave.
    reset_i = 1'b1;
    #1;
    src0.push_back('{8'h10, 1'b0}); src0.push_back('{8'h11, 1'b1});
    src1.push_back('{8'h20, 1'b0}); src1.push_back('{8'h21, 1'b1});
    en0 = 1'b1;
    en1 = 1'b1;
    drive();
    chk("rst_force_tx_v", 32'(tx_v_o), 32'd0);
    chk("rst_force_grant", 32'(grant_o), 32'd0);
    chk("rst_force_ready", 32'(req_ready_and_o), 32'd0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("s2_grant", 32'(grant_o), 32'b01);
    chk("s2_first", 32'(tx_o), 32'h10);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
    chk("s2_drained", 32'(exp_q.size()), 32'd0);
    src0.push_back('{8'h30, 1'b1});
    src1.push_back('{8'h40, 1'b1});
    exp_q.push_back(8'h30); exp_q.push_back(8'h40);
    drive();
    chk("s2_next_contention", 32'(grant_o), 32'b01);
    tick();
    chk("s2_rr_second", 32'(grant_o), 32'b10);
    tick();
    chk("s2b_drained", 32'(exp_q.size()), 32'd0);

    // Req1 holds the lock while req0 waits.
    en0 = 1'b0;
    src1.push_back('{8'h50, 1'b0}); src1.push_back('{8'h51, 1'b0}); src1.push_back('{8'h52, 1'b1});
    src0.push_back('{8'h60, 1'b1});
    exp_q.push_back(8'h50); exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h60);
    drive();
    chk("s3_grant1", 32'(grant_o), 32'b10);
    tick();
    en0 = 1'b1;
    drive();
    chk("s3_ready0_a", 32'(req_ready_and_o[0]), 32'd0);
    chk("s3_busy", 32'(busy_o), 32'd1);
    tick();
    chk("s3_ready0_b", 32'(req_ready_and_o[0]), 32'd0);
    tick();
    chk("s3_grant0", 32'(grant_o), 32'b01);
    chk("s3_ready0_c", 32'(req_ready_and_o), 32'b01);
    tick();
    chk("s3_drained", 32'(exp_q.size()), 32'd0);

    // Idle owner timeout.
    en1 = 1'b0;
    src0.push_back('{8'h70, 1'b0}); src0.push_back('{8'h71, 1'b1});
    src1.push_back('{8'h80, 1'b1});
    exp_q.push_back(8'h70);
    drive();
    chk("s4_grant0", 32'(grant_o), 32'b01);
    tick();
    en0 = 1'b0;
    en1 = 1'b1;
    drive();
    chk("s4_busy", 32'(busy_o), 32'd1);
    chk("s4_grant_locked", 32'(grant_o), 32'b01);
    chk("s4_ready1", 32'(req_ready_and_o[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("s4_no_early_timeout", 32'(timeout_o), 32'd0);
      tick();
    end
    chk("s4_timeout", 32'(timeout_o), 32'd1);
    chk("s4_timeout_id", 32'(timeout_id_o), 32'd0);
    chk("s4_grant1", 32'(grant_o), 32'b10);
    chk("s4_busy_after", 32'(busy_o), 32'd0);
    exp_q.push_back(8'h80);
    tick();
    chk("s4_pulse_once", 32'(timeout_o), 32'd0);
    chk("s4_id_hold", 32'(timeout_id_o), 32'd0);
    en0 = 1'b1;
    exp_q.push_back(8'h71);
    drive();
    tick();
    chk("s4_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure while locked.
    en1 = 1'b0;
    src0.push_back('{8'h90, 1'b0}); src0.push_back('{8'h91, 1'b0}); src0.push_back('{8'h92, 1'b1});
    exp_q.push_back(8'h90);
    drive();
    tick();
    tx_ready_and_i = 1'b0;
    drive();
    for (int i = 0; i < 10; i++) begin
      chk("s5_tx_v", 32'(tx_v_o), 32'd1);
      chk("s5_tx_stable", 32'(tx_o), 32'h91);
      chk("s5_ready", 32'(req_ready_and_o), 32'd0);
      chk("s5_timeout", 32'(timeout_o), 32'd0);
      chk("s5_busy", 32'(busy_o), 32'd1);
      tick();
    end
    tx_ready_and_i = 1'b1;
    exp_q.push_back(8'h91); exp_q.push_back(8'h92);
    drive();
    tick();
    tick();
    chk("s5_busy_after", 32'(busy_o), 32'd0);
    chk("s5_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-packet abandons the lock.
    en0 = 1'b0;
    en1 = 1'b1;
    src1.push_back('{8'hA0, 1'b0}); src1.push_back('{8'hA1, 1'b0}); src1.push_back('{8'hA2, 1'b1});
    exp_q.push_back(8'hA0);
    drive();
    chk("s6_grant1", 32'(grant_o), 32'b10);
    tick();
    reset_i = 1'b1;
    #1;
    chk("s6_rst_tx_v", 32'(tx_v_o), 32'd0);
    chk("s6_rst_grant", 32'(grant_o), 32'd0);
    chk("s6_rst_ready", 32'(req_ready_and_o), 32'd0);
    chk("s6_rst_busy", 32'(busy_o), 32'd0);
    tick();
    chk("s6_rst_tx_v2", 32'(tx_v_o), 32'd0);
    src1.delete();
    src1.push_back('{8'hC0, 1'b1});
    src0.push_back('{8'hB0, 1'b1});
    en0 = 1'b1;
    drive();
    reset_i = 1'b0;
    #1;
    chk("s6_busy_release", 32'(busy_o), 32'd0);
    chk("s6_grant0", 32'(grant_o), 32'b01);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hC0);
    tick();
    tick();
    chk("s6_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
